axi_lite_to_apb: RTL
====================

AXI_LITE_TO_APB -- requirements
Module: axi_lite_to_apb

Interface
REQ-001 Parameter AddrWidth, default 32'd32: width of the AXI4-Lite and APB addresses.
REQ-002 Parameter DataWidth, default 32'd32: width of the data bus, a multiple of 8 up to 32.
REQ-003 Parameter lite_req_t, default logic: AXI4-Lite request struct (aw, aw_valid, w, w_valid, b_ready, ar, ar_valid, r_ready).
REQ-004 Parameter lite_resp_t, default logic: AXI4-Lite response struct (aw_ready, w_ready, b, b_valid, ar_ready, r, r_valid).
REQ-005 clk_i  in  1  clock; the block has a single clock.
REQ-006 rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 slv_req_i  in  lite_req_t  AXI4-Lite slave request.
REQ-008 slv_resp_o  out  lite_resp_t  AXI4-Lite slave response.
REQ-009 paddr_o  out  AddrWidth  APB address.
REQ-010 pprot_o  out  3  APB protection, copied from aw.prot or ar.prot.
REQ-011 psel_o, penable_o, pwrite_o  out  1 each  APB control signals.
REQ-012 pwdata_o  out  DataWidth  APB write data.
REQ-013 pstrb_o  out  DataWidth/8  APB write strobe.
REQ-014 pready_i, pslverr_i  in  1 each  APB completion and error inputs.
REQ-015 prdata_i  in  DataWidth  APB read data.

Function
REQ-016 The FSM SHALL have four states: IDLE, SETUP, ACCESS, RESP; only one transaction SHALL be in flight at a time.
REQ-017 A write SHALL be eligible in IDLE only when aw_valid and w_valid are both high; AW and W SHALL be accepted in the same cycle, aw_ready == w_ready.
REQ-018 A read SHALL be eligible in IDLE when ar_valid is high.
REQ-019 Arbitration between reads and writes SHALL be round-robin:
- a priority flag SHALL select the winner when both are eligible;
- the flag SHALL point to the other type after every grant;
- the flag SHALL reset to write-first.
REQ-020 Ready signals SHALL be high only in IDLE and only for the granted type.
REQ-021 Ready signals SHALL be combinational from valid and state; on the handshake the block SHALL register:
- addr, prot and write/read type;
- wdata and strb for writes, zero strb for reads;
- then move to SETUP.
REQ-022 SETUP SHALL last exactly one cycle with psel_o=1, penable_o=0; the next state SHALL be ACCESS.
REQ-023 ACCESS SHALL hold psel_o=1 and penable_o=1 until pready_i=1.
REQ-024 paddr_o, pwrite_o, pwdata_o, pstrb_o and pprot_o SHALL stay stable from SETUP through the completing ACCESS cycle.
REQ-025 On pready_i=1 in ACCESS, the block SHALL register prdata_i (reads) and resp = pslverr_i ? 2'b10 (SLVERR) : 2'b00 (OKAY), then move to RESP.
REQ-026 In RESP, b_valid (writes) or r_valid (reads) SHALL be high with the registered resp and data.
REQ-027 Response payload SHALL stay stable until b_ready or r_ready; the handshake cycle SHALL return the FSM to IDLE.
REQ-028 Minimum latency from AW/W or AR handshake (cycle T) to b_valid or r_valid SHALL be 3 cycles (SETUP T+1, ACCESS T+2 with pready, RESP T+3).
REQ-029 A new request SHALL NOT be accepted in the cycle a response handshakes; acceptance SHALL resume in the following IDLE cycle.
REQ-030 Outside SETUP and ACCESS, psel_o and penable_o SHALL be 0.
REQ-031 pready_i, pslverr_i and prdata_i SHALL be ignored outside ACCESS.
REQ-032 An AW without W (or W without AW) SHALL NOT be accepted and SHALL NOT block a pending AR.

Reset
REQ-033 On rst_ni low, asynchronously:
- state SHALL be IDLE and the priority flag write-first;
- all APB outputs, b_valid, r_valid and all registered payloads SHALL be 0.
REQ-034 Reset during SETUP, ACCESS or RESP SHALL abandon the transaction with no response issued.

Verification
REQ-035 Write addr 0x10, data 0xDEADBEEF, strb 0xF, pready high at first ACCESS ->
- psel T+1, penable T+2, pwrite=1;
- b_valid at T+3 with resp 2'b00.
REQ-036 Read addr 0x20, pready delayed 4 ACCESS cycles, prdata 0x12345678 -> r.data 0x12345678, r.resp 2'b00, r_valid at T+6, APB outputs stable throughout.
REQ-037 Read with pslverr=1 -> r.resp 2'b10; write with pslverr=1 -> b.resp 2'b10.
REQ-038 AR, AW and W valid continuously from reset -> grants alternate W,R,W,R, first grant write.
REQ-039 b_ready held low 5 cycles -> b_valid and b.resp stable, no new AR accepted; accepted the cycle after the handshake.
REQ-040 rst_ni low in ACCESS -> psel_o=0 and penable_o=0 immediately; after release, no b_valid or r_valid until a new request.

Source files
------------

// File: rtl/axi_lite_to_apb.sv
// -----------------------------------------------------------------------------
// axi_lite_to_apb
//   Bridges an AXI4-Lite slave port onto an APB master port, one transaction
//   at a time. A read or write request is accepted in IDLE. The APB SETUP and
//   ACCESS phases are then driven. The completion (prdata / pslverr) is
//   registered, and the B or R response is held until the manager accepts it.
//   Reads and writes are arbitrated round-robin, starting with writes.
//
// Ports
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   slv_req_i             AXI4-Lite request  (aw, aw_valid, w, w_valid, b_ready,
//                                             ar, ar_valid, r_ready)
//   slv_resp_o            AXI4-Lite response (aw_ready, w_ready, b, b_valid,
//                                             ar_ready, r, r_valid)
//   paddr_o, pprot_o      APB address / protection
//   psel_o, penable_o     APB phase control
//   pwrite_o              APB direction (1 = write)
//   pwdata_o, pstrb_o     APB write data / strobe (strobe is zero for reads)
//   pready_i, pslverr_i   APB completion / error
//   prdata_i              APB read data
// -----------------------------------------------------------------------------

package axi_lite_to_apb_pkg;

  // Default 32-bit AXI4-Lite channel and bundle types used by the bridge.
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  prot;
  } aw_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } w_chan_t;

  typedef struct packed {
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  prot;
  } ar_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } lite_req_t;

  typedef struct packed {
    logic     aw_ready;
    logic     w_ready;
    b_chan_t  b;
    logic     b_valid;
    logic     ar_ready;
    r_chan_t  r;
    logic     r_valid;
  } lite_resp_t;

endpackage

module axi_lite_to_apb #(
  parameter int unsigned AddrWidth = 32'd32,
  parameter int unsigned DataWidth = 32'd32,
  parameter type lite_req_t  = axi_lite_to_apb_pkg::lite_req_t,
  parameter type lite_resp_t = axi_lite_to_apb_pkg::lite_resp_t
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  lite_req_t              slv_req_i,
  output lite_resp_t             slv_resp_o,
  output logic [AddrWidth-1:0]   paddr_o,
  output logic [2:0]             pprot_o,
  output logic                   psel_o,
  output logic                   penable_o,
  output logic                   pwrite_o,
  output logic [DataWidth-1:0]   pwdata_o,
  output logic [DataWidth/8-1:0] pstrb_o,
  input  logic                   pready_i,
  input  logic                   pslverr_i,
  input  logic [DataWidth-1:0]   prdata_i
);

  localparam int unsigned StrbWidth = DataWidth / 8;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10,
    RESP   = 2'b11
  } state_e;

  state_e                 state_q;
  logic                   wr_prio_q;  // 1: a write wins when both are eligible
  logic [AddrWidth-1:0]   paddr_q;
  logic [2:0]             pprot_q;
  logic                   pwrite_q;
  logic [DataWidth-1:0]   pwdata_q;
  logic [StrbWidth-1:0]   pstrb_q;
  logic [DataWidth-1:0]   rdata_q;
  logic [1:0]             resp_q;

  logic wr_elig;
  logic rd_elig;
  logic grant_wr;
  logic grant_rd;
  logic resp_done;

  // Eligibility and round-robin grant; a write needs AW and W together.
  always_comb begin
    wr_elig  = (state_q == IDLE) && slv_req_i.aw_valid && slv_req_i.w_valid;
    rd_elig  = (state_q == IDLE) && slv_req_i.ar_valid;
    grant_wr = wr_elig && (wr_prio_q || !rd_elig);
    grant_rd = rd_elig && !grant_wr;
    if (state_q == RESP) begin
      resp_done = pwrite_q ? slv_req_i.b_ready : slv_req_i.r_ready;
    end else begin
      resp_done = 1'b0;
    end
  end

  // Bridge FSM with its registered APB payload and response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      wr_prio_q <= 1'b1;
      paddr_q   <= '0;
      pprot_q   <= 3'b000;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= RespOkay;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_wr) begin
            paddr_q   <= slv_req_i.aw.addr;
            pprot_q   <= slv_req_i.aw.prot;
            pwrite_q  <= 1'b1;
            pwdata_q  <= slv_req_i.w.data;
            pstrb_q   <= slv_req_i.w.strb;
            wr_prio_q <= 1'b0;
            state_q   <= SETUP;
          end else if (grant_rd) begin
            paddr_q   <= slv_req_i.ar.addr;
            pprot_q   <= slv_req_i.ar.prot;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            wr_prio_q <= 1'b1;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          state_q <= ACCESS;
        end
        ACCESS: begin
          if (pready_i) begin
            if (!pwrite_q) begin
              rdata_q <= prdata_i;
            end
            resp_q  <= pslverr_i ? RespSlvErr : RespOkay;
            state_q <= RESP;
          end
        end
        RESP: begin
          // Return to IDLE on the handshake; acceptance resumes next cycle.
          if (resp_done) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // APB outputs decode straight from registered state and payload.
  always_comb begin
    psel_o    = (state_q == SETUP) || (state_q == ACCESS);
    penable_o = (state_q == ACCESS);
    paddr_o   = paddr_q;
    pprot_o   = pprot_q;
    pwrite_o  = pwrite_q;
    pwdata_o  = pwdata_q;
    pstrb_o   = pstrb_q;
  end

  // AXI4-Lite response: readies from the grant, B/R from registered state.
  always_comb begin
    slv_resp_o          = '0;
    slv_resp_o.aw_ready = grant_wr;
    slv_resp_o.w_ready  = grant_wr;
    slv_resp_o.ar_ready = grant_rd;
    slv_resp_o.b_valid  = (state_q == RESP) && pwrite_q;
    slv_resp_o.b.resp   = resp_q;
    slv_resp_o.r_valid  = (state_q == RESP) && !pwrite_q;
    slv_resp_o.r.data   = rdata_q;
    slv_resp_o.r.resp   = resp_q;
  end

endmodule
